// File: rtl/cve2_pkg.sv
// Shared types for the cve2 writeback slice: stage FSM encoding and the
// instruction record held between EX and the register file.
package cve2_pkg;

  typedef enum logic [1:0] {
    WB_IDLE = 2'd0,
    WB_FULL = 2'd1,
    WB_LOAD = 2'd2
  } wb_state_e;

  typedef struct packed {
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] result;
  } wb_instr_t;

  localparam wb_instr_t WB_INSTR_RESET = '{we: 1'b0, waddr: 5'd0, result: 32'd0};

  // Writes to the upper half of the register file do not exist on RV32E.
  function automatic logic rv32e_illegal(input logic rv32e, input logic we,
                                         input logic [4:0] waddr);
    return rv32e & we & waddr[4];
  endfunction

endpackage

// File: rtl/cve2_wb_stage_if.sv
// EX -> WB completion handshake. EX drives the instruction, WB answers
// with ready in the same cycle.
interface cve2_wb_stage_if;
  logic        ex_valid;
  logic        ex_rf_we;
  logic [4:0]  ex_rf_waddr;
  logic [31:0] ex_result;
  logic        ex_is_load;
  logic        wb_ready;

  modport master (
    output ex_valid, ex_rf_we, ex_rf_waddr, ex_result, ex_is_load,
    input  wb_ready
  );

  modport slave (
    input  ex_valid, ex_rf_we, ex_rf_waddr, ex_result, ex_is_load,
    output wb_ready
  );
endinterface

// File: rtl/cve2_wb_stage.sv
// Writeback stage: one held instruction, written one cycle after accept;
// loads wait in WB_LOAD until the LSU response and write combinationally.
module cve2_wb_stage
  import cve2_pkg::*;
#(
  parameter bit RV32E = 1'b0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  cve2_wb_stage_if.slave    ex_if,
  input  logic              flush_i,
  input  logic              lsu_resp_valid_i,
  input  logic [31:0]       lsu_rdata_i,
  input  logic              lsu_err_i,
  output logic              rf_we_o,
  output logic [4:0]        rf_waddr_o,
  output logic [31:0]       rf_wdata_o,
  output logic              load_pending_o,
  output logic [4:0]        load_waddr_o,
  output logic              load_err_o,
  output logic              waddr_illegal_o,
  output logic              instr_retired_o
);

  wb_state_e state_q, state_d;
  wb_instr_t instr_q, instr_d;

  logic wb_ready;
  logic accept;
  logic load_done;
  logic retire;
  logic rv32e_bad;
  logic we_ok;

  assign wb_ready    = (state_q != WB_LOAD) | lsu_resp_valid_i;
  assign ex_if.wb_ready = wb_ready;
  assign accept      = ex_if.ex_valid & wb_ready & ~flush_i;
  assign load_done   = (state_q == WB_LOAD) & lsu_resp_valid_i;
  assign retire      = (state_q == WB_FULL) | load_done;
  assign rv32e_bad   = rv32e_illegal(RV32E, instr_q.we, instr_q.waddr);
  assign we_ok       = instr_q.we & (instr_q.waddr != 5'd0) & ~rv32e_bad;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= WB_IDLE;
      instr_q <= WB_INSTR_RESET;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
    end
  end

  // A pending load only leaves WB_LOAD on its response; once it has, the
  // stage behaves exactly as if it were free this cycle.
  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    if (accept) begin
      state_d = ex_if.ex_is_load ? WB_LOAD : WB_FULL;
      instr_d = '{we: ex_if.ex_rf_we, waddr: ex_if.ex_rf_waddr, result: ex_if.ex_result};
    end else if ((state_q != WB_LOAD) || lsu_resp_valid_i) begin
      state_d = WB_IDLE;
    end
  end

  always_comb begin
    rf_we_o    = 1'b0;
    rf_waddr_o = 5'd0;
    rf_wdata_o = 32'd0;
    if (state_q == WB_FULL) begin
      rf_we_o = we_ok;
    end else if (load_done) begin
      rf_we_o = we_ok & ~lsu_err_i;
    end
    if (rf_we_o) begin
      rf_waddr_o = instr_q.waddr;
      rf_wdata_o = load_done ? lsu_rdata_i : instr_q.result;
    end
  end

  assign load_pending_o  = (state_q == WB_LOAD) & ~lsu_resp_valid_i;
  assign load_waddr_o    = load_pending_o ? instr_q.waddr : 5'd0;
  assign load_err_o      = load_done & lsu_err_i;
  assign waddr_illegal_o = retire & rv32e_bad;
  assign instr_retired_o = retire;

`ifndef SYNTHESIS
  // A reset that drops an outstanding load leaves one response in flight on
  // the bus; that single stray response is legal and ignored.
  logic orphan_resp_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      orphan_resp_q <= orphan_resp_q | (state_q == WB_LOAD);
    end else if (lsu_resp_valid_i && (state_q != WB_LOAD)) begin
      orphan_resp_q <= 1'b0;
    end
  end

  a_resp_only_in_load : assert property (
    @(posedge clk_i) disable iff (rst_i)
    (lsu_resp_valid_i && (state_q != WB_LOAD)) |-> orphan_resp_q
  );
`endif

endmodule

// File: tb/tb_cve2_wb_stage.sv
// Directed bench for cve2_wb_stage: stimulus pushes expected retirements,
// a negedge monitor pops and compares them against the DUT.
module tb_cve2_wb_stage;
  import cve2_pkg::*;

  typedef struct packed {
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        err;
    logic        ill;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic        ex_valid, ex_we, ex_load, flush;
  logic [4:0]  ex_waddr;
  logic [31:0] ex_result;
  logic        lsu_valid, lsu_err;
  logic [31:0] lsu_rdata;

  logic        rf_we0, pend0, lerr0, ill0, ret0;
  logic [4:0]  rf_waddr0, lwaddr0;
  logic [31:0] rf_wdata0;
  logic        rf_we1, pend1, lerr1, ill1, ret1;
  logic [4:0]  rf_waddr1, lwaddr1;
  logic [31:0] rf_wdata1;

  int total = 0;
  int bad   = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  cve2_wb_stage_if ex_if0 ();
  cve2_wb_stage_if ex_if1 ();

  assign ex_if0.ex_valid    = ex_valid;
  assign ex_if0.ex_rf_we    = ex_we;
  assign ex_if0.ex_rf_waddr = ex_waddr;
  assign ex_if0.ex_result   = ex_result;
  assign ex_if0.ex_is_load  = ex_load;
  assign ex_if1.ex_valid    = ex_valid;
  assign ex_if1.ex_rf_we    = ex_we;
  assign ex_if1.ex_rf_waddr = ex_waddr;
  assign ex_if1.ex_result   = ex_result;
  assign ex_if1.ex_is_load  = ex_load;

  cve2_wb_stage #(.RV32E(1'b0)) dut (
    .clk_i(clk), .rst_i(rst), .ex_if(ex_if0), .flush_i(flush),
    .lsu_resp_valid_i(lsu_valid), .lsu_rdata_i(lsu_rdata), .lsu_err_i(lsu_err),
    .rf_we_o(rf_we0), .rf_waddr_o(rf_waddr0), .rf_wdata_o(rf_wdata0),
    .load_pending_o(pend0), .load_waddr_o(lwaddr0), .load_err_o(lerr0),
    .waddr_illegal_o(ill0), .instr_retired_o(ret0)
  );

  cve2_wb_stage #(.RV32E(1'b1)) dut_e (
    .clk_i(clk), .rst_i(rst), .ex_if(ex_if1), .flush_i(flush),
    .lsu_resp_valid_i(lsu_valid), .lsu_rdata_i(lsu_rdata), .lsu_err_i(lsu_err),
    .rf_we_o(rf_we1), .rf_waddr_o(rf_waddr1), .rf_wdata_o(rf_wdata1),
    .load_pending_o(pend1), .load_waddr_o(lwaddr1), .load_err_o(lerr1),
    .waddr_illegal_o(ill1), .instr_retired_o(ret1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic idle();
    ex_valid = 1'b0; ex_we = 1'b0; ex_waddr = 5'd0; ex_result = 32'd0;
    ex_load = 1'b0; flush = 1'b0;
    lsu_valid = 1'b0; lsu_rdata = 32'd0; lsu_err = 1'b0;
  endtask

  task automatic ex(input logic [4:0] a, input logic [31:0] r, input logic ld);
    ex_valid = 1'b1; ex_we = 1'b1; ex_waddr = a; ex_result = r; ex_load = ld;
  endtask

  task automatic resp(input logic [31:0] d, input logic e);
    lsu_valid = 1'b1; lsu_rdata = d; lsu_err = e;
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic push(input logic we, input logic [4:0] a, input logic [31:0] d,
                      input logic e, input logic il);
    exp_q.push_back('{we: we, waddr: a, wdata: d, err: e, ill: il});
  endtask

  // Monitor: every retirement of the RV32E=0 instance is matched in order.
  always @(negedge clk) begin
    if (!rst && ret0) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL retire_unexpected: got retire with waddr %0d expected none", rf_waddr0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("mon_we",    {31'd0, rf_we0}, {31'd0, e.we});
        check("mon_waddr", {27'd0, rf_waddr0}, {27'd0, e.waddr});
        check("mon_wdata", rf_wdata0, e.wdata);
        check("mon_lerr",  {31'd0, lerr0}, {31'd0, e.err});
        check("mon_ill",   {31'd0, ill0}, {31'd0, e.ill});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    idle();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    check("rst_we",     {31'd0, rf_we0}, 32'd0);
    check("rst_waddr",  {27'd0, rf_waddr0}, 32'd0);
    check("rst_wdata",  rf_wdata0, 32'd0);
    check("rst_pend",   {31'd0, pend0}, 32'd0);
    check("rst_lwaddr", {27'd0, lwaddr0}, 32'd0);
    check("rst_ret",    {31'd0, ret0}, 32'd0);
    check("rst_ready",  {31'd0, ex_if0.wb_ready}, 32'd1);
    nxt();

    // Back-to-back ALU
    ex(5'd5, 32'h1234, 1'b0); push(1, 5, 32'h1234, 0, 0);
    @(negedge clk); check("b2b_ready0", {31'd0, ex_if0.wb_ready}, 32'd1);
    nxt();
    ex(5'd6, 32'hABCD, 1'b0); push(1, 6, 32'hABCD, 0, 0);
    @(negedge clk); check("b2b_ready1", {31'd0, ex_if0.wb_ready}, 32'd1);
    check("b2b_we_x5", {31'd0, rf_we0}, 32'd1);
    nxt();
    @(negedge clk); check("b2b_ready2", {31'd0, ex_if0.wb_ready}, 32'd1);
    nxt();

    // Load with a 3-cycle wait
    ex(5'd7, 32'h0999, 1'b1); push(1, 7, 32'hDEADBEEF, 0, 0);
    nxt();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("ld_pend",   {31'd0, pend0}, 32'd1);
      check("ld_lwaddr", {27'd0, lwaddr0}, 32'd7);
      check("ld_ready",  {31'd0, ex_if0.wb_ready}, 32'd0);
      check("ld_nowe",   {31'd0, rf_we0}, 32'd0);
      nxt();
    end
    resp(32'hDEADBEEF, 1'b0);
    @(negedge clk);
    check("ld_resp_pend",  {31'd0, pend0}, 32'd0);
    check("ld_resp_ready", {31'd0, ex_if0.wb_ready}, 32'd1);
    nxt();

    // Response and new accept in the same cycle
    ex(5'd8, 32'h0, 1'b1); push(1, 8, 32'h8888, 0, 0);
    nxt();
    resp(32'h8888, 1'b0);
    ex(5'd9, 32'h55, 1'b0); push(1, 9, 32'h55, 0, 0);
    @(negedge clk); check("ovl_ready", {31'd0, ex_if0.wb_ready}, 32'd1);
    nxt();
    @(negedge clk); check("ovl_x9_we", {31'd0, rf_we0}, 32'd1);
    nxt();

    // Load error
    ex(5'd10, 32'h0, 1'b1); push(0, 0, 32'h0, 1, 0);
    nxt();
    resp(32'hBAD0BAD0, 1'b1);
    @(negedge clk); check("err_ret", {31'd0, ret0}, 32'd1);
    nxt();

    // x0, then x20 (illegal only on the RV32E instance)
    ex(5'd0, 32'h77, 1'b0); push(0, 0, 32'h0, 0, 0);
    nxt();
    ex(5'd20, 32'h20, 1'b0); push(1, 20, 32'h20, 0, 0);
    @(negedge clk); check("x0_we_e", {31'd0, rf_we1}, 32'd0);
    nxt();
    @(negedge clk);
    check("e_we",  {31'd0, rf_we1}, 32'd0);
    check("e_ill", {31'd0, ill1}, 32'd1);
    check("e_ret", {31'd0, ret1}, 32'd1);
    nxt();
    @(negedge clk); check("e_ill_pulse", {31'd0, ill1}, 32'd0);
    nxt();

    // Flush drops the offered instruction; the held one still writes
    ex(5'd11, 32'h11, 1'b0); push(1, 11, 32'h11, 0, 0);
    nxt();
    ex(5'd12, 32'h12, 1'b0); flush = 1'b1;
    @(negedge clk); check("fl_held_we", {31'd0, rf_we0}, 32'd1);
    nxt();
    @(negedge clk);
    check("fl_drop_we",  {31'd0, rf_we0}, 32'd0);
    check("fl_drop_ret", {31'd0, ret0}, 32'd0);
    nxt();

    // Reset in the middle of a load, then a stray response
    ex(5'd13, 32'h0, 1'b1);
    nxt();
    @(negedge clk); check("rml_pend", {31'd0, pend0}, 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("rml_pend_rst",  {31'd0, pend0}, 32'd0);
    check("rml_ready_rst", {31'd0, ex_if0.wb_ready}, 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    resp(32'h13131313, 1'b0);
    @(negedge clk);
    check("rml_we",     {31'd0, rf_we0}, 32'd0);
    check("rml_waddr",  {27'd0, rf_waddr0}, 32'd0);
    check("rml_wdata",  rf_wdata0, 32'd0);
    check("rml_ret",    {31'd0, ret0}, 32'd0);
    check("rml_lerr",   {31'd0, lerr0}, 32'd0);
    check("rml_pend",   {31'd0, pend0}, 32'd0);
    check("rml_ready",  {31'd0, ex_if0.wb_ready}, 32'd1);
    nxt();
    @(negedge clk);

    check("sb_empty", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
